// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: two-stage ARM-style shift unit (LSL/LSR/ASR/ROR/RRX)
// with immediate or register amounts, full carry-out semantics, and valid/ready
// handshakes on both sides.
// Stage 1 classifies the request and performs the coarse (multiple-of-8) shift.
// Stage 2 performs the fine shift, selects the carry and drives the outputs.
// Optional macro SHIFTER_FLAGS_EN adds registered shift_n / shift_z outputs.
module pipelined_barrel_shifter #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8,
  parameter int LOG_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        shift_op,
  input  logic [DATA_W-1:0] shift_data,
  input  logic [AMT_W-1:0]  shift_num,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] shift_out,
  output logic              shift_carry_out
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic              shift_n,
  output logic              shift_z
`endif
);

  // Amount comparisons need room for both the full amount and the value DATA_W.
  localparam int CMP_W = (AMT_W > LOG_W + 1) ? AMT_W : LOG_W + 1;
  localparam logic [CMP_W-1:0] W_EXT     = CMP_W'(DATA_W);
  localparam logic [LOG_W-1:0] FINE_MASK = LOG_W'(7);

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  // Resolved behaviour of a request once the amount has been classified.
  typedef enum logic [2:0] {
    M_PASS,     // out = data, carry = carry_in
    M_SHIFT,    // ordinary shift/rotate by 1..DATA_W-1
    M_ZERO_HI,  // LSL/LSR by exactly DATA_W
    M_ZERO,     // LSL/LSR beyond DATA_W
    M_SIGN,     // ASR by DATA_W or more
    M_RRX,      // rotate right through carry
    M_ROR0      // register ROR by a non-zero multiple of DATA_W
  } mode_t;

  // Shift or rotate by amt; composes cleanly, so coarse then fine equals the total.
  function automatic logic [DATA_W-1:0] shift_by(input logic [1:0]        typ,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic [LOG_W-1:0]  amt);
    logic signed [DATA_W-1:0] sd;
    logic [2*DATA_W-1:0]      dd;
    sd = d;
    dd = {d, d} >> amt;
    case (typ)
      T_LSL:   shift_by = d << amt;
      T_LSR:   shift_by = d >> amt;
      T_ASR:   shift_by = sd >>> amt;
      default: shift_by = dd[DATA_W-1:0];
    endcase
  endfunction

  logic vld_p1, vld_p2;
  logic adv_p2, accept;

  assign adv_p2    = !vld_p2 || out_ready;
  assign in_ready  = !vld_p1 || adv_p2;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_p2;

  // ---- stage 1: classify amount, coarse shift ----
  logic [1:0]        typ_c;
  logic [CMP_W-1:0]  n_ext_c;
  logic [LOG_W-1:0]  sh_c;
  mode_t             mode_c;
  logic [DATA_W-1:0] coarse_c;

  // Decode the effective amount and special cases, then shift by the 8-bit multiple.
  always_comb begin
    typ_c    = shift_op[2:1];
    n_ext_c  = CMP_W'(shift_num);
    sh_c     = shift_num[LOG_W-1:0];
    mode_c   = M_SHIFT;
    if (shift_op[0]) begin
      if (n_ext_c == '0) begin
        mode_c = M_PASS;
      end else begin
        case (typ_c)
          T_ROR:   mode_c = (sh_c == '0) ? M_ROR0 : M_SHIFT;
          T_ASR:   mode_c = (n_ext_c >= W_EXT) ? M_SIGN : M_SHIFT;
          default: begin
            if (n_ext_c == W_EXT)     mode_c = M_ZERO_HI;
            else if (n_ext_c > W_EXT) mode_c = M_ZERO;
            else                      mode_c = M_SHIFT;
          end
        endcase
      end
    end else if (sh_c == '0) begin
      case (typ_c)
        T_LSL:   mode_c = M_PASS;
        T_LSR:   mode_c = M_ZERO_HI;
        T_ASR:   mode_c = M_SIGN;
        default: mode_c = M_RRX;
      endcase
    end
    coarse_c = shift_by(typ_c, shift_data, sh_c & ~FINE_MASK);
  end

  logic [1:0]        typ_p1;
  mode_t             mode_p1;
  logic [LOG_W-1:0]  sh_p1;
  logic [DATA_W-1:0] data_p1;
  logic [DATA_W-1:0] coarse_p1;
  logic              cin_p1;

  // Stage-1 occupancy: refills whenever the slot is free or moving on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  // Stage-1 payload captured on every accepted request.
  always_ff @(posedge clk) begin
    if (accept) begin
      typ_p1    <= typ_c;
      mode_p1   <= mode_c;
      sh_p1     <= sh_c;
      data_p1   <= shift_data;
      coarse_p1 <= coarse_c;
      cin_p1    <= carry_in;
    end
  end

  // ---- stage 2: fine shift, carry select ----
  logic [DATA_W-1:0] fine_c;
  logic [DATA_W-1:0] res_c;
  logic              carry_c;
  logic [LOG_W-1:0]  idx_l, idx_r;

  // Finish the shift and pick the carry bit for the resolved mode.
  always_comb begin
    fine_c  = shift_by(typ_p1, coarse_p1, sh_p1 & FINE_MASK);
    idx_l   = LOG_W'(0) - sh_p1;
    idx_r   = sh_p1 - LOG_W'(1);
    res_c   = data_p1;
    carry_c = cin_p1;
    case (mode_p1)
      M_SHIFT: begin
        res_c = fine_c;
        if (typ_p1 == T_LSL)      carry_c = data_p1[idx_l];
        else if (typ_p1 == T_ROR) carry_c = fine_c[DATA_W-1];
        else                      carry_c = data_p1[idx_r];
      end
      M_ZERO_HI: begin
        res_c   = '0;
        carry_c = (typ_p1 == T_LSL) ? data_p1[0] : data_p1[DATA_W-1];
      end
      M_ZERO: begin
        res_c   = '0;
        carry_c = 1'b0;
      end
      M_SIGN: begin
        res_c   = {DATA_W{data_p1[DATA_W-1]}};
        carry_c = data_p1[DATA_W-1];
      end
      M_RRX: begin
        res_c   = {cin_p1, data_p1[DATA_W-1:1]};
        carry_c = data_p1[0];
      end
      M_ROR0: begin
        res_c   = data_p1;
        carry_c = data_p1[DATA_W-1];
      end
      default: begin
        res_c   = data_p1;
        carry_c = cin_p1;
      end
    endcase
  end

  // Output register: loads on advance, holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2          <= 1'b0;
      shift_out       <= '0;
      shift_carry_out <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
      shift_n         <= 1'b0;
      shift_z         <= 1'b0;
`endif
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        shift_out       <= res_c;
        shift_carry_out <= carry_c;
`ifdef SHIFTER_FLAGS_EN
        shift_n         <= res_c[DATA_W-1];
        shift_z         <= (res_c == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Testbench for pipelined_barrel_shifter: directed vector table, handshake
// corner sequences (back-pressure, mid-flight reset) and randomized traffic
// scored against a wide-arithmetic reference model.
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  shift_op;
  logic [31:0] shift_data;
  logic [7:0]  shift_num;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] shift_out;
  logic        shift_carry_out;

  pipelined_barrel_shifter #(.DATA_W(32), .AMT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .shift_op(shift_op), .shift_data(shift_data), .shift_num(shift_num),
    .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .shift_out(shift_out), .shift_carry_out(shift_carry_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [7:0]  num;
    logic        cin;
    logic [31:0] exp_out;
    logic        exp_c;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: shifts computed on 64-bit extended vectors from the ARM rules.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] d,
                                        input logic [7:0] num, input logic cin);
    int unsigned n;
    int unsigned r;
    logic [63:0] p;
    logic signed [63:0] sp;
    logic [31:0] o;
    n = op[0] ? 32'(num) : 32'(num[4:0]);
    if (n == 0) begin
      if (op[0] || op[2:1] == 2'b00) return {cin, d};
      if (op[2:1] == 2'b11) return {d[0], cin, d[31:1]};
      n = 32;
    end
    case (op[2:1])
      2'b00: begin
        p = {32'b0, d} << n;
        return {p[32], p[31:0]};
      end
      2'b01: begin
        p = {d, 32'b0} >> n;
        return {p[31], p[63:32]};
      end
      2'b10: begin
        sp = $signed({d, 32'b0}) >>> n;
        return {sp[31], sp[63:32]};
      end
      default: begin
        r = n % 32;
        if (r == 0) return {d[31], d};
        o = (d >> r) | (d << (32 - r));
        return {o[31], o};
      end
    endcase
  endfunction

  // Present one request and hold it until accepted (bounded).
  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [7:0] num,
                      input logic cin, input logic [32:0] e, input string name);
    int cnt;
    cnt = 0;
    shift_op   = op;
    shift_data = d;
    shift_num  = num;
    carry_in   = cin;
    in_valid   = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
    while (!in_ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout %s: in_ready stayed %b, expected 1", name, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been consumed.
  task automatic drain(input string name);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Scoreboard plus stall-stability monitor, sampled mid-cycle.
  logic        stalled_prev = 1'b0;
  logic [31:0] held_out;
  logic        held_c;
  logic [32:0] mon_e;
  string       mon_n;
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_out", 64'(shift_out), 64'(held_out));
        check("hold_carry", 64'(shift_carry_out), 64'(held_c));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h, expected no result", shift_out);
        end else begin
          mon_e = exp_q.pop_front();
          mon_n = name_q.pop_front();
          check(mon_n, 64'({shift_carry_out, shift_out}), 64'(mon_e));
        end
      end
      stalled_prev = out_valid && !out_ready;
      held_out     = shift_out;
      held_c       = shift_carry_out;
    end
  end

  bit rand_done = 1'b0;

  initial begin
    vecs[0]  = '{3'b011, 32'h80000001, 8'd1,   1'b0, 32'h40000000, 1'b1};
    vecs[1]  = '{3'b010, 32'h80000000, 8'd0,   1'b0, 32'h00000000, 1'b1};
    vecs[2]  = '{3'b011, 32'h80000000, 8'd40,  1'b0, 32'h00000000, 1'b0};
    vecs[3]  = '{3'b101, 32'h80000000, 8'd33,  1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{3'b110, 32'h00000003, 8'd0,   1'b1, 32'h80000001, 1'b1};
    vecs[5]  = '{3'b111, 32'h80000000, 8'd64,  1'b0, 32'h80000000, 1'b1};
    vecs[6]  = '{3'b000, 32'h12345678, 8'd0,   1'b1, 32'h12345678, 1'b1};
    vecs[7]  = '{3'b001, 32'h00000001, 8'd32,  1'b0, 32'h00000000, 1'b1};
    vecs[8]  = '{3'b001, 32'hFFFFFFFF, 8'd33,  1'b1, 32'h00000000, 1'b0};
    vecs[9]  = '{3'b000, 32'hF0000001, 8'd4,   1'b0, 32'h00000010, 1'b1};
    vecs[10] = '{3'b100, 32'h7FFFFFFF, 8'd0,   1'b1, 32'h00000000, 1'b0};
    vecs[11] = '{3'b011, 32'h80000000, 8'd32,  1'b0, 32'h00000000, 1'b1};
    vecs[12] = '{3'b101, 32'h80000000, 8'd0,   1'b0, 32'h80000000, 1'b0};
    vecs[13] = '{3'b111, 32'h0000000F, 8'd4,   1'b0, 32'hF0000000, 1'b1};
    vecs[14] = '{3'b111, 32'h0000000F, 8'd36,  1'b0, 32'hF0000000, 1'b1};
    vecs[15] = '{3'b100, 32'h80000000, 8'd4,   1'b1, 32'hF8000000, 1'b0};
    vecs[16] = '{3'b011, 32'hFFFFFFFF, 8'd255, 1'b1, 32'h00000000, 1'b0};
    vecs[17] = '{3'b101, 32'h7FFFFFFF, 8'd255, 1'b1, 32'h00000000, 1'b0};
    vecs[18] = '{3'b000, 32'h00000001, 8'h21,  1'b1, 32'h00000002, 1'b0};
    vecs[19] = '{3'b111, 32'h00000001, 8'd32,  1'b1, 32'h00000001, 1'b0};
    vecs[20] = '{3'b010, 32'h80000000, 8'd31,  1'b1, 32'h00000001, 1'b0};
    vecs[21] = '{3'b001, 32'h00000003, 8'd31,  1'b0, 32'h80000000, 1'b1};

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    shift_op   = '0;
    shift_data = '0;
    shift_num  = '0;
    carry_in   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_shift_out", 64'(shift_out), 64'd0);
    check("rst_carry", 64'(shift_carry_out), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency on the first vector, then the rest of the table back-to-back
    out_ready = 1'b1;
    send(vecs[0].op, vecs[0].data, vecs[0].num, vecs[0].cin,
         {vecs[0].exp_c, vecs[0].exp_out}, "vec0");
    check("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 64'(out_valid), 64'd1);
    for (int i = 1; i < 22; i++) begin
      send(vecs[i].op, vecs[i].data, vecs[i].num, vecs[i].cin,
           {vecs[i].exp_c, vecs[i].exp_out}, $sformatf("vec%0d", i));
    end
    drain("table_drain");

    // Back-pressure: 4 LSL immediates, consumer stalled for 3 cycles
    out_ready = 1'b0;
    send(3'b000, 32'h1, 8'd0, 1'b0, {1'b0, 32'h1}, "bp0");
    send(3'b000, 32'h1, 8'd1, 1'b0, {1'b0, 32'h2}, "bp1");
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    fork
      begin
        send(3'b000, 32'h1, 8'd2, 1'b0, {1'b0, 32'h4}, "bp2");
        send(3'b000, 32'h1, 8'd3, 1'b0, {1'b0, 32'h8}, "bp3");
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset with two requests in flight
    out_ready = 1'b0;
    send(3'b001, 32'hAAAA5555, 8'd3, 1'b0, 33'h0, "stale0");
    send(3'b011, 32'hAAAA5555, 8'd3, 1'b0, 33'h0, "stale1");
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    name_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(3'b011, 32'h80000001, 8'd1, 1'b0, {1'b1, 32'h40000000}, "post_rst");
    check("post_rst_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    drain("post_rst_drain");

    // Randomized traffic with random consumer stalls
    fork
      begin
        logic [2:0]  op;
        logic [31:0] d;
        logic [7:0]  num;
        logic        cin;
        for (int i = 0; i < 300; i++) begin
          op  = 3'($urandom_range(0, 7));
          d   = $urandom;
          num = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
          cin = 1'($urandom_range(0, 1));
          send(op, d, num, cin, model(op, d, num, cin), $sformatf("rand%0d", i));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
